vga_timing_rx: RTL

Receive-side counterpart of the VGA_TFT timing generator. Samples an incoming HS/VS/BLK/RGB stream (one pixel per Clk) and measures line and frame geometry. Once the geometry holds for two consecutive frames it locks, then tags every active pixel with x/y coordinates for downstream capture, checking or a frame-buffer writer. Used on board loopback and in simulation as a self-checking monitor for VGA_TFT.

---
 rtl/vga_timing_rx.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures line/frame geometry of an HS/VS/BLK/RGB stream,
// locks after two matching frames and tags each active pixel with x/y coordinates.
module vga_timing_rx #(
  parameter int CNT_W  = 12,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int RGB_W  = 24
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic             VGA_BLK,
  input  logic [RGB_W-1:0] VGA_RGB,
  output logic             Pix_Valid,
  output logic [RGB_W-1:0] Pix_RGB,
  output logic [CNT_W-1:0] Pix_X,
  output logic [CNT_W-1:0] Pix_Y,
  output logic             Frame_Start,
  output logic [CNT_W-1:0] H_Total,
  output logic [CNT_W-1:0] H_Active,
  output logic [CNT_W-1:0] V_Total,
  output logic [CNT_W-1:0] V_Active,
  output logic             Locked,
  output logic             Err
);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic             HS_ACT   = (HS_POL != 0);
  localparam logic             VS_ACT   = (VS_POL != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t state, state_nxt;

  logic             hs_p0, vs_p0, blk_p0;
  logic [RGB_W-1:0] rgb_p0;
  logic             hs_p1, vs_p1, blk_p1, ls_p1, fs_p1;
  logic [RGB_W-1:0] rgb_p1;

  logic [CNT_W-1:0] hcnt, de_cnt, vcnt, acnt, y_cnt;
  logic             line_ok, have_h;
  logic [CNT_W-1:0] cand_ht, cand_ha, cand_vt, cand_va;

  logic             line_act, line_chk, h_bad, v_bad, oob, sat;
  logic [CNT_W-1:0] v_tot_c, a_tot_c, x_cur, y_cur;
  logic             err_set, lock_set, cand_h_ld, cand_v_ld, have_h_clr;

  // Stage p0: capture inputs, syncs normalised so 1 = asserted
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
      blk_p0 <= 1'b0;
    end else begin
      hs_p0  <= VGA_HS ~^ HS_ACT;
      vs_p0  <= VGA_VS ~^ VS_ACT;
      blk_p0 <= VGA_BLK;
    end
  end

  always_ff @(posedge Clk) begin
    rgb_p0 <= VGA_RGB;
    rgb_p1 <= rgb_p0;
  end

  // Stage p1: edge detection; ls_p1/fs_p1 mark the sample now in blk_p1/rgb_p1
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      blk_p1 <= 1'b0;
      ls_p1  <= 1'b0;
      fs_p1  <= 1'b0;
    end else begin
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      blk_p1 <= blk_p0;
      ls_p1  <= hs_p0 & ~hs_p1;
      fs_p1  <= vs_p0 & ~vs_p1;
    end
  end

  // Line/frame close values; the closing LS is folded in before a coincident FS
  assign line_act = (de_cnt != CNT_ZERO);
  assign line_chk = ls_p1 & line_ok & line_act;
  assign v_tot_c  = ls_p1 ? sat_inc(vcnt) : vcnt;
  assign a_tot_c  = (ls_p1 & line_act) ? sat_inc(acnt) : acnt;
  assign h_bad    = line_chk & ((hcnt != cand_ht) | (de_cnt != cand_ha));
  assign v_bad    = fs_p1 & ((v_tot_c != cand_vt) | (a_tot_c != cand_va));
  assign x_cur    = ls_p1 ? CNT_ZERO : de_cnt;
  assign oob      = blk_p1 & (x_cur >= cand_ha);
  assign sat      = ~ls_p1 & (hcnt == CNT_MAX);
  assign y_cur    = fs_p1 ? CNT_ZERO :
                    (ls_p1 & line_act) ? sat_inc(y_cnt) : y_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hcnt    <= CNT_ZERO;
      de_cnt  <= CNT_ZERO;
      vcnt    <= CNT_ZERO;
      acnt    <= CNT_ZERO;
      y_cnt   <= CNT_ZERO;
      line_ok <= 1'b0;
      have_h  <= 1'b0;
    end else begin
      if (ls_p1) begin
        hcnt    <= CNT_ONE;
        de_cnt  <= CNT_W'(blk_p1);
        line_ok <= 1'b1;
      end else begin
        hcnt <= sat_inc(hcnt);
        if (blk_p1) de_cnt <= sat_inc(de_cnt);
        if (sat) line_ok <= 1'b0;
      end
      if (fs_p1) begin
        vcnt <= CNT_ZERO;
        acnt <= CNT_ZERO;
      end else begin
        vcnt <= v_tot_c;
        acnt <= a_tot_c;
      end
      y_cnt <= y_cur;
      if (have_h_clr)     have_h <= 1'b0;
      else if (cand_h_ld) have_h <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    err_set    = 1'b0;
    lock_set   = 1'b0;
    cand_h_ld  = 1'b0;
    cand_v_ld  = 1'b0;
    have_h_clr = 1'b0;
    case (state)
      SEARCH: begin
        if (fs_p1) begin
          state_nxt  = MEASURE;
          have_h_clr = 1'b1;
        end
      end
      MEASURE: begin
        if (line_chk & ~have_h) cand_h_ld = 1'b1;
        if (fs_p1) begin
          if (have_h | line_chk) begin
            cand_v_ld = 1'b1;
            state_nxt = VERIFY;
          end else begin
            err_set   = 1'b1;
            state_nxt = SEARCH;
          end
        end
      end
      VERIFY: begin
        if (h_bad | v_bad | oob) begin
          err_set   = 1'b1;
          state_nxt = SEARCH;
        end else if (fs_p1) begin
          lock_set  = 1'b1;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (h_bad | v_bad | oob) begin
          err_set   = 1'b1;
          state_nxt = SEARCH;
        end
      end
    endcase
    if (sat) begin
      err_set   = 1'b1;
      lock_set  = 1'b0;
      cand_v_ld = 1'b0;
      state_nxt = SEARCH;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cand_ht  <= CNT_ZERO;
      cand_ha  <= CNT_ZERO;
      cand_vt  <= CNT_ZERO;
      cand_va  <= CNT_ZERO;
      H_Total  <= CNT_ZERO;
      H_Active <= CNT_ZERO;
      V_Total  <= CNT_ZERO;
      V_Active <= CNT_ZERO;
      Locked   <= 1'b0;
      Err      <= 1'b0;
    end else begin
      if (cand_h_ld) begin
        cand_ht <= hcnt;
        cand_ha <= de_cnt;
      end
      if (cand_v_ld) begin
        cand_vt <= v_tot_c;
        cand_va <= a_tot_c;
      end
      if (lock_set) begin
        H_Total  <= cand_ht;
        H_Active <= cand_ha;
        V_Total  <= cand_vt;
        V_Active <= cand_va;
      end
      Locked <= (state_nxt == LOCKED);
      if (err_set)       Err <= 1'b1;
      else if (lock_set) Err <= 1'b0;
    end
  end

  // Stage p2: registered pixel outputs, three clocks after the input sample
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Pix_Valid   <= 1'b0;
      Pix_RGB     <= '0;
      Pix_X       <= CNT_ZERO;
      Pix_Y       <= CNT_ZERO;
      Frame_Start <= 1'b0;
    end else begin
      Pix_Valid   <= blk_p1 & Locked;
      Pix_RGB     <= rgb_p1;
      Pix_X       <= x_cur;
      Pix_Y       <= y_cur;
      Frame_Start <= blk_p1 & Locked & (x_cur == CNT_ZERO) & (y_cur == CNT_ZERO);
    end
  end

endmodule
